// File: rtl/c17_bist_ctrl_pkg.sv
// Shared types and constants for the c17 BIST controller slice.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int unsigned      PAT_W         = 5;
  localparam logic [PAT_W-1:0] LFSR_TAPS_DEF = 5'b10100;
  localparam logic [15:0]      MISR_TAPS_DEF = 16'h1021;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits
  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] v,
                                                 input logic [PAT_W-1:0] taps);
    return {v[PAT_W-2:0], ^(v & taps)};
  endfunction

endpackage

// File: rtl/c17_bist_ctrl_if.sv
// BIST controller <-> bench/CUT signal bundle; the controller takes the slave side.
interface c17_bist_ctrl_if
  import c17_bist_pkg::*;
#(
  parameter int unsigned MISR_W = 16
);
  logic              start;
  logic [PAT_W-1:0]  pat_out;
  logic [1:0]        resp_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  modport master (output start, resp_in,
                  input  pat_out, busy, done, pass, signature);
  modport slave  (input  start, resp_in,
                  output pat_out, busy, done, pass, signature);
endinterface

// File: rtl/c17_bist_ctrl_misr.sv
// Multiple-input signature register compacting the 2-bit c17 response stream.
module c17_bist_misr #(
  parameter int unsigned       MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS = 16'h1021
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [1:0]        data,
  output logic [MISR_W-1:0] sig,
  output logic [MISR_W-1:0] sig_nxt
);
  logic [MISR_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_TAPS : '0)
            ^ MISR_W'(data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig     = sig_q;
  assign sig_nxt = sig_d;
endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the registered c17 CUT: LFSR patterns out, MISR signature in.
// Define C17_BIST_EXHAUSTIVE_EN to replace the LFSR by a 0..31 up-counter (32 patterns).
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned       NUM_PATTERNS = 31,
  parameter logic [PAT_W-1:0]  LFSR_SEED    = 5'b00001,
  parameter logic [PAT_W-1:0]  LFSR_TAPS    = LFSR_TAPS_DEF,
  parameter int unsigned       CUT_LAT      = 2,
  parameter int unsigned       MISR_W       = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS    = MISR_TAPS_DEF,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0
) (
  input logic            clk,
  input logic            reset,
  c17_bist_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 6;

`ifdef C17_BIST_EXHAUSTIVE_EN
  localparam int unsigned      NUM_PAT_EFF = 32;
  localparam logic [PAT_W-1:0] FIRST_PAT   = '0;

  function automatic logic [PAT_W-1:0] gen_next(input logic [PAT_W-1:0] v);
    return v + PAT_W'(1);
  endfunction
`else
  localparam int unsigned      NUM_PAT_EFF = NUM_PATTERNS;
  localparam logic [PAT_W-1:0] FIRST_PAT   = (LFSR_SEED == '0) ? PAT_W'(1) : LFSR_SEED;

  function automatic logic [PAT_W-1:0] gen_next(input logic [PAT_W-1:0] v);
    return lfsr_next(v, LFSR_TAPS);
  endfunction
`endif

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   gen_q, gen_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CUT_LAT-1:0] vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               misr_clr;
  logic [MISR_W-1:0]  sig, sig_nxt;

  // gen_q always holds the pattern to show next; the start edge loads the first one directly
  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    pat_d    = pat_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    vld_d    = (vld_q << 1) | CUT_LAT'(state_q == ST_RUN);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          pat_d    = FIRST_PAT;
          gen_d    = gen_next(FIRST_PAT);
          cnt_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(NUM_PAT_EFF - 1)) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          pat_d = gen_q;
          gen_d = gen_next(gen_q);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // last response is absorbed on this same edge, so judge the next signature
        if (cnt_q == CNT_W'(CUT_LAT - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (sig_nxt == GOLDEN_SIG);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gen_q   <= FIRST_PAT;
      pat_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  c17_bist_misr #(
    .MISR_W    (MISR_W),
    .MISR_TAPS (MISR_TAPS)
  ) u_misr (
    .clk     (clk),
    .reset   (reset),
    .clr     (misr_clr),
    .en      (vld_q[CUT_LAT-1]),
    .data    (bus.resp_in),
    .sig     (sig),
    .sig_nxt (sig_nxt)
  );

  assign bus.pat_out   = pat_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl with a registered behavioural c17 CUT and fault injection.
module tb_c17_bist_ctrl;
  localparam logic [4:0] SEED = 5'b00001;
`ifdef C17_BIST_EXHAUSTIVE_EN
  localparam int unsigned NP = 32;
`else
  localparam int unsigned NP = 31;
`endif

  // i-th applied pattern (0-based)
  function automatic logic [4:0] pattern_at(input int unsigned i);
`ifdef C17_BIST_EXHAUSTIVE_EN
    return 5'(i);
`else
    logic [4:0] v = SEED;
    for (int unsigned j = 0; j < i; j++) v = {v[3:0], v[4] ^ v[2]};
    return v;
`endif
  endfunction

  // c17 netlist, returns {N22,N23}; p = {N1,N2,N3,N6,N7}
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[4] & p[2]);
    n11 = ~(p[2] & p[1]);
    n16 = ~(p[3] & n11);
    n19 = ~(n11 & p[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  // fault 1: N22 stuck-at-0, fault 2: N23 stuck-at-1
  function automatic logic [1:0] with_fault(input logic [1:0] r, input int unsigned f);
    logic [1:0] o;
    o = r;
    if (f == 1) o[1] = 1'b0;
    if (f == 2) o[0] = 1'b1;
    return o;
  endfunction

  // signature after the first n responses have been compacted
  function automatic logic [15:0] sig_after(input int unsigned f, input int unsigned n);
    logic [15:0] s = '0;
    for (int unsigned j = 0; j < n; j++)
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000)
        ^ {14'b0, with_fault(c17(pattern_at(j)), f)};
    return s;
  endfunction

  localparam logic [15:0] GOLDEN = sig_after(0, NP);

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int unsigned fault = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  c17_bist_ctrl_if #(.MISR_W(16)) bus ();

  c17_bist_ctrl #(
    .NUM_PATTERNS (31),
    .LFSR_SEED    (SEED),
    .LFSR_TAPS    (5'b10100),
    .CUT_LAT      (2),
    .MISR_W       (16),
    .MISR_TAPS    (16'h1021),
    .GOLDEN_SIG   (GOLDEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // registered CUT: input register then output register
  logic [4:0] cut_in_q;
  logic [1:0] cut_out_q;
  always @(posedge clk) begin
    cut_in_q  <= bus.pat_out;
    cut_out_q <= c17(cut_in_q);
  end
  assign bus.resp_in = with_fault(cut_out_q, fault);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
    chk({tag, "_pass"}, 32'(bus.pass), 32'(0));
    chk({tag, "_pat"},  32'(bus.pat_out), 32'(0));
    chk({tag, "_sig"},  32'(bus.signature), 32'(0));
  endtask

  // full run; ign>0 pulses start during RUN cycle ign, which must be ignored
  task automatic run_full(input int unsigned f, input int unsigned ign);
    int unsigned kk, nabs;
    logic [15:0] s_exp;
    fault = f;
    @(negedge clk);
    bus.start = 1'b1;
    for (int unsigned k = 1; k <= NP + 3; k++) begin
      @(negedge clk);
      bus.start = (k == ign);
      kk   = (k < NP) ? k : NP;
      nabs = (k > 3) ? k - 3 : 0;
      if (nabs > NP) nabs = NP;
      chk("pat",  32'(bus.pat_out), 32'(pattern_at(kk - 1)));
      chk("sig",  32'(bus.signature), 32'(sig_after(f, nabs)));
      chk("busy", 32'(bus.busy), 32'(k < NP + 3));
      chk("done", 32'(bus.done), 32'(k == NP + 3));
      if (k < NP + 3) chk("pass_run", 32'(bus.pass), 32'(0));
    end
    bus.start = 1'b0;
    s_exp = sig_after(f, NP);
    chk("pass_final", 32'(bus.pass), 32'(s_exp == GOLDEN));
    @(negedge clk);
    chk("done_held", 32'(bus.done), 32'(1));
    chk("sig_frozen", 32'(bus.signature), 32'(s_exp));
  endtask

  // start a run and assert reset during RUN cycle r
  task automatic run_abort(input int unsigned r);
    @(negedge clk);
    bus.start = 1'b1;
    for (int unsigned k = 1; k <= r; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("abort_pat", 32'(bus.pat_out), 32'(pattern_at(k - 1)));
    end
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    reset = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    run_full(0, 0);
    run_full(1, 0);
    chk("sa0_sig_differs", 32'(bus.signature != GOLDEN), 32'(1));
    run_full(0, 5);
    run_abort(10);
    run_full(0, 0);

    repeat (6) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        run_abort($urandom_range(1, NP));
      else
        run_full($urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? $urandom_range(1, NP) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
